// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Command front-end for the ALU unit bank (arith / logic / cmp /
//               shift). Accepts one operation over a valid/ready handshake,
//               latches its operands and function onto the shared unit bus,
//               pulses the selected unit's enable for one cycle, captures that
//               unit's registered result and flag, and presents them over a
//               second valid/ready handshake. Completed results are counted.
//
// Ports       : CLK          clock, all state on the rising edge
//               RST          asynchronous reset, active-low
//               CMD_VALID    command valid
//               CMD_READY    command ready (high only in IDLE, out of reset)
//               CMD_A/CMD_B  command operands            [WIDTH]
//               CMD_FUN      [3:2] unit select, [1:0] unit op
//               ALU_A/ALU_B  operands to all units       [WIDTH]
//               ALU_OP       op code to all units        [2]
//               *_EN         unit enables, one-hot or zero
//               *_OUT        registered unit results     [WIDTH]
//               *_FLAG       registered unit valid flags
//               RES_VALID    result valid
//               RES_READY    result consumed on VALID & READY
//               RES_DATA     captured result             [WIDTH]
//               RES_ERR      selected unit flag was low at capture
//               OP_COUNT     completed-result counter    [CNT_W], wraps
//
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  // command side
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [WIDTH-1:0] CMD_A,
  input  logic [WIDTH-1:0] CMD_B,
  input  logic [3:0]       CMD_FUN,
  // unit bank side
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [1:0]       ALU_OP,
  output logic             ARITH_EN,
  output logic             LOGIC_EN,
  output logic             CMP_EN,
  output logic             SHIFT_EN,
  input  logic [WIDTH-1:0] ARITH_OUT,
  input  logic [WIDTH-1:0] LOGIC_OUT,
  input  logic [WIDTH-1:0] CMP_OUT,
  input  logic [WIDTH-1:0] SHIFT_OUT,
  input  logic             ARITH_FLAG,
  input  logic             LOGIC_FLAG,
  input  logic             CMP_FLAG,
  input  logic             SHIFT_FLAG,
  // result side
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [WIDTH-1:0] RES_DATA,
  output logic             RES_ERR,
  output logic [CNT_W-1:0] OP_COUNT
);

  localparam logic [1:0] C_UNIT_ARITH = 2'b00;
  localparam logic [1:0] C_UNIT_LOGIC = 2'b01;
  localparam logic [1:0] C_UNIT_CMP   = 2'b10;
  localparam logic [1:0] C_UNIT_SHIFT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_cmd_ready;
  logic             w_accept;
  logic             w_capture;
  logic             w_complete;

  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [1:0]       r_alu_op;
  logic [1:0]       r_unit;
  logic [3:0]       r_en;        // {shift, cmp, logic, arith}
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_err;
  logic [CNT_W-1:0] r_op_count;

  logic [WIDTH-1:0] w_sel_out;
  logic             w_sel_flag;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and control decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ready = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Gated by RST so that ready stays low for the whole reset interval,
        // even though the state register already reads IDLE.
        w_cmd_ready = RST;
        if (CMD_VALID) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_capture   = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (RES_READY) begin
          w_complete  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Result select: the unit registered its result on the edge that ended
  // ISSUE, so during CAPTURE its OUT/FLAG reflect this command.
  // --------------------------------------------------------------------------
  always_comb begin
    w_sel_out  = ARITH_OUT;
    w_sel_flag = ARITH_FLAG;
    case (r_unit)
      C_UNIT_ARITH: begin
        w_sel_out  = ARITH_OUT;
        w_sel_flag = ARITH_FLAG;
      end
      C_UNIT_LOGIC: begin
        w_sel_out  = LOGIC_OUT;
        w_sel_flag = LOGIC_FLAG;
      end
      C_UNIT_CMP: begin
        w_sel_out  = CMP_OUT;
        w_sel_flag = CMP_FLAG;
      end
      C_UNIT_SHIFT: begin
        w_sel_out  = SHIFT_OUT;
        w_sel_flag = SHIFT_FLAG;
      end
      default: begin
        w_sel_out  = ARITH_OUT;
        w_sel_flag = ARITH_FLAG;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_unit      <= '0;
      r_en        <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_err   <= 1'b0;
      r_op_count  <= '0;
    end else begin
      // Accept only happens in IDLE, so the enable is high exactly for the
      // ISSUE cycle and is cleared on the edge into CAPTURE.
      if (w_accept) begin
        r_alu_a  <= CMD_A;
        r_alu_b  <= CMD_B;
        r_alu_op <= CMD_FUN[1:0];
        r_unit   <= CMD_FUN[3:2];
        r_en     <= 4'b0001 << CMD_FUN[3:2];
      end else begin
        r_en     <= '0;
      end

      if (w_capture) begin
        r_res_data  <= w_sel_out;
        r_res_err   <= ~w_sel_flag;
        r_res_valid <= 1'b1;
      end else if (w_complete) begin
        r_res_valid <= 1'b0;
        r_op_count  <= r_op_count + CNT_W'(1);
      end
    end
  end

  assign CMD_READY = w_cmd_ready;
  assign ALU_A     = r_alu_a;
  assign ALU_B     = r_alu_b;
  assign ALU_OP    = r_alu_op;
  assign ARITH_EN  = r_en[0];
  assign LOGIC_EN  = r_en[1];
  assign CMP_EN    = r_en[2];
  assign SHIFT_EN  = r_en[3];
  assign RES_VALID = r_res_valid;
  assign RES_DATA  = r_res_data;
  assign RES_ERR   = r_res_err;
  assign OP_COUNT  = r_op_count;

endmodule
`default_nettype wire
